// File: rtl/l2_req_scheduler_if.sv
// Line-request bus between the three requesters, the scheduler and the L2 line port.
// The master modport is the scheduler's view. The slave modport is the
// environment's view: D-cache, I-cache, prefetcher and the downstream L2 side.
interface l2_req_scheduler_if #(
    parameter int ADDR_W = 32,
    parameter int LINE_W = 256
);
    // D-cache requester
    logic [ADDR_W-1:0] d_address;
    logic              d_read;
    logic              d_write;
    logic [LINE_W-1:0] d_wdata;
    logic              d_resp;
    logic [LINE_W-1:0] d_rdata;
    // I-cache requester
    logic [ADDR_W-1:0] i_address;
    logic              i_read;
    logic              i_write;
    logic [LINE_W-1:0] i_wdata;
    logic              i_resp;
    logic [LINE_W-1:0] i_rdata;
    // Next-line prefetcher (read only)
    logic [ADDR_W-1:0] pf_address;
    logic              pf_read;
    logic              pf_resp;
    logic [LINE_W-1:0] pf_rdata;
    // Downstream line port
    logic [ADDR_W-1:0] mem_address;
    logic              mem_read;
    logic              mem_write;
    logic [LINE_W-1:0] mem_wdata;
    logic              mem_resp;
    logic [LINE_W-1:0] mem_rdata;

    modport master (
        input  d_address, d_read, d_write, d_wdata,
        output d_resp, d_rdata,
        input  i_address, i_read, i_write, i_wdata,
        output i_resp, i_rdata,
        input  pf_address, pf_read,
        output pf_resp, pf_rdata,
        output mem_address, mem_read, mem_write, mem_wdata,
        input  mem_resp, mem_rdata
    );

    modport slave (
        output d_address, d_read, d_write, d_wdata,
        input  d_resp, d_rdata,
        output i_address, i_read, i_write, i_wdata,
        input  i_resp, i_rdata,
        output pf_address, pf_read,
        input  pf_resp, pf_rdata,
        input  mem_address, mem_read, mem_write, mem_wdata,
        output mem_resp, mem_rdata
    );
endinterface

// File: rtl/l2_req_scheduler.sv
// Three-way line request scheduler (D > I > PF, with an I-cache starvation escape)
// in front of the single shared L2 line port. It handles one transaction at a time.
// All outputs come from registers, so no request input reaches an output
// combinationally.
module l2_req_scheduler #(
    parameter int ADDR_W       = 32,
    parameter int LINE_W       = 256,
    parameter int STARVE_LIMIT = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    l2_req_scheduler_if.master    bus
);
    localparam int CNT_W = $clog2(STARVE_LIMIT + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STARVE_LIMIT);

    typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;
    typedef enum logic [1:0] {OWN_D, OWN_I, OWN_PF} owner_t;

    state_t            state, state_next;
    owner_t            owner_q;
    logic              op_write_q;
    logic [ADDR_W-1:0] addr_q;
    logic [LINE_W-1:0] wdata_q;
    logic [LINE_W-1:0] rdata_q;
    logic [CNT_W-1:0]  starve_cnt;

    logic              d_pend, i_pend, pf_pend;
    logic              grant_any, grant_d, grant_i, grant_pf;
    owner_t            grant_owner;
    logic              grant_write;
    logic [ADDR_W-1:0] grant_addr;
    logic [LINE_W-1:0] grant_wdata;
    logic [CNT_W-1:0]  cnt_next;

    assign d_pend  = bus.d_read | bus.d_write;
    assign i_pend  = bus.i_read | bus.i_write;
    assign pf_pend = bus.pf_read;

    // Winner selection and the starvation counter update for a grant in IDLE
    always_comb begin
        grant_d     = 1'b0;
        grant_i     = 1'b0;
        grant_pf    = 1'b0;
        grant_owner = OWN_D;
        grant_write = 1'b0;
        grant_addr  = '0;
        grant_wdata = '0;
        cnt_next    = starve_cnt;
        if (i_pend && (starve_cnt == CNT_MAX)) begin
            grant_i = 1'b1;
        end else if (d_pend) begin
            grant_d = 1'b1;
        end else if (i_pend) begin
            grant_i = 1'b1;
        end else if (pf_pend) begin
            grant_pf = 1'b1;
        end
        if (grant_d) begin
            grant_owner = OWN_D;
            grant_write = bus.d_write;
            grant_addr  = bus.d_address;
            grant_wdata = bus.d_wdata;
            if (i_pend && (starve_cnt != CNT_MAX)) begin
                cnt_next = starve_cnt + 1'b1;
            end
        end else if (grant_i) begin
            grant_owner = OWN_I;
            grant_write = bus.i_write;
            grant_addr  = bus.i_address;
            grant_wdata = bus.i_wdata;
            cnt_next    = '0;
        end else if (grant_pf) begin
            grant_owner = OWN_PF;
            grant_addr  = bus.pf_address;
        end
    end

    assign grant_any = grant_d | grant_i | grant_pf;

    // Next-state logic: IDLE -> BUSY on a grant, BUSY -> RESP on mem_resp, RESP -> IDLE
    always_comb begin
        state_next = state;
        unique case (state)
            IDLE:    if (grant_any) state_next = BUSY;
            BUSY:    if (bus.mem_resp) state_next = RESP;
            RESP:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // State register; reset drops any transaction in flight without a response
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Latch the winning request on grant and capture the returned line on mem_resp
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            owner_q    <= OWN_D;
            op_write_q <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
            rdata_q    <= '0;
            starve_cnt <= '0;
        end else begin
            if ((state == IDLE) && grant_any) begin
                owner_q    <= grant_owner;
                op_write_q <= grant_write;
                addr_q     <= grant_addr;
                wdata_q    <= grant_wdata;
                starve_cnt <= cnt_next;
            end
            if ((state == BUSY) && bus.mem_resp) begin
                rdata_q <= bus.mem_rdata;
            end
        end
    end

    // Downstream command is held for the whole BUSY phase; write wins over read
    assign bus.mem_read    = (state == BUSY) && !op_write_q;
    assign bus.mem_write   = (state == BUSY) && op_write_q;
    assign bus.mem_address = addr_q;
    assign bus.mem_wdata   = wdata_q;

    // All requesters see the captured line; only the owner gets the resp pulse
    assign bus.d_resp   = (state == RESP) && (owner_q == OWN_D);
    assign bus.i_resp   = (state == RESP) && (owner_q == OWN_I);
    assign bus.pf_resp  = (state == RESP) && (owner_q == OWN_PF);
    assign bus.d_rdata  = rdata_q;
    assign bus.i_rdata  = rdata_q;
    assign bus.pf_rdata = rdata_q;
endmodule

// File: tb/tb_l2_req_scheduler.sv
// Directed testbench for l2_req_scheduler. Inputs are driven and outputs are
// sampled 1 time unit after each rising clock edge.
module tb_l2_req_scheduler;
    localparam int ADDR_W = 32;
    localparam int LINE_W = 256;

    logic clk;
    logic rst;
    int   checks;
    int   errors;

    l2_req_scheduler_if #(.ADDR_W(ADDR_W), .LINE_W(LINE_W)) bus ();

    l2_req_scheduler #(.ADDR_W(ADDR_W), .LINE_W(LINE_W), .STARVE_LIMIT(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk1(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic chka(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chkl(input string tag, input logic [LINE_W-1:0] obs, input logic [LINE_W-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_resp(input string tag, input logic d, input logic i, input logic pf);
        chk1({tag, "_d_resp"}, bus.d_resp, d);
        chk1({tag, "_i_resp"}, bus.i_resp, i);
        chk1({tag, "_pf_resp"}, bus.pf_resp, pf);
    endtask

    // Called in the first BUSY cycle; returns in the RESP cycle.
    // The downstream latency n counts BUSY cycles including the mem_resp cycle.
    task automatic serve(input int n, input logic [LINE_W-1:0] line);
        for (int c = 1; c < n; c++) tick();
        bus.mem_rdata = line;
        bus.mem_resp  = 1'b1;
        tick();
        bus.mem_resp  = 1'b0;
        bus.mem_rdata = '0;
    endtask

    localparam logic [LINE_W-1:0] R1 = {8{32'hDEAD_0001}};
    localparam logic [LINE_W-1:0] R2 = {8{32'h1234_5678}};
    localparam logic [LINE_W-1:0] R3 = {8{32'hA5A5_0F0F}};
    localparam logic [LINE_W-1:0] R4 = {8{32'h0BAD_F00D}};
    localparam logic [LINE_W-1:0] W1 = {8{32'hCAFE_BABE}};
    localparam logic [LINE_W-1:0] W2 = {8{32'h5555_AAAA}};

    initial begin
        checks = 0;
        errors = 0;
        rst = 1'b1;
        bus.d_address = '0; bus.d_read = 1'b0; bus.d_write = 1'b0; bus.d_wdata = '0;
        bus.i_address = '0; bus.i_read = 1'b0; bus.i_write = 1'b0; bus.i_wdata = '0;
        bus.pf_address = '0; bus.pf_read = 1'b0;
        bus.mem_resp = 1'b0; bus.mem_rdata = '0;
        tick();
        tick();
        rst = 1'b0;
        tick();

        // Reset state
        chk1("rst_mem_read", bus.mem_read, 1'b0);
        chk1("rst_mem_write", bus.mem_write, 1'b0);
        chka("rst_mem_address", bus.mem_address, 32'h0);
        chkl("rst_mem_wdata", bus.mem_wdata, '0);
        chk_resp("rst", 1'b0, 1'b0, 1'b0);
        chkl("rst_d_rdata", bus.d_rdata, '0);
        chka("rst_starve_cnt", 32'(dut.starve_cnt), 32'd0);

        // Single D read at 0x1000 with downstream latency 5
        bus.d_address = 32'h0000_1000;
        bus.d_read    = 1'b1;
        tick();
        chk1("t1_mem_read_c1", bus.mem_read, 1'b1);
        chka("t1_mem_address", bus.mem_address, 32'h0000_1000);
        chk1("t1_mem_write_c1", bus.mem_write, 1'b0);
        tick(); tick(); tick();
        chk1("t1_mem_read_c4", bus.mem_read, 1'b1);
        chk_resp("t1_busy", 1'b0, 1'b0, 1'b0);
        tick();
        chk1("t1_mem_read_c5", bus.mem_read, 1'b1);
        bus.mem_rdata = R1;
        bus.mem_resp  = 1'b1;
        tick();
        bus.mem_resp  = 1'b0;
        bus.mem_rdata = '0;
        chk1("t1_mem_read_c6", bus.mem_read, 1'b0);
        chk_resp("t1_resp", 1'b1, 1'b0, 1'b0);
        chkl("t1_d_rdata", bus.d_rdata, R1);
        bus.d_read = 1'b0;
        tick();
        chk_resp("t1_idle", 1'b0, 1'b0, 1'b0);
        tick();
        chk1("t1_no_regrant", bus.mem_read, 1'b0);

        // Same-cycle D write, I read, PF read: served D, I, PF
        bus.d_address  = 32'h0000_2000; bus.d_write = 1'b1; bus.d_wdata = W1;
        bus.i_address  = 32'h0000_3000; bus.i_read  = 1'b1;
        bus.pf_address = 32'h0000_4000; bus.pf_read = 1'b1;
        tick();
        chk1("t2_d_mem_write", bus.mem_write, 1'b1);
        chk1("t2_d_mem_read", bus.mem_read, 1'b0);
        chka("t2_d_address", bus.mem_address, 32'h0000_2000);
        chkl("t2_d_wdata", bus.mem_wdata, W1);
        serve(2, R1);
        chk_resp("t2_d_resp", 1'b1, 1'b0, 1'b0);
        bus.d_write = 1'b0;
        tick();
        chk_resp("t2_idle1", 1'b0, 1'b0, 1'b0);
        tick();
        chk1("t2_i_mem_read", bus.mem_read, 1'b1);
        chka("t2_i_address", bus.mem_address, 32'h0000_3000);
        serve(1, R2);
        chk_resp("t2_i_resp", 1'b0, 1'b1, 1'b0);
        chkl("t2_i_rdata", bus.i_rdata, R2);
        bus.i_read = 1'b0;
        tick();
        tick();
        chk1("t2_pf_mem_read", bus.mem_read, 1'b1);
        chka("t2_pf_address", bus.mem_address, 32'h0000_4000);
        serve(1, R3);
        chk_resp("t2_pf_resp", 1'b0, 1'b0, 1'b1);
        chkl("t2_pf_rdata", bus.pf_rdata, R3);
        bus.pf_read = 1'b0;
        tick();
        chka("t2_starve_cnt", 32'(dut.starve_cnt), 32'd0);

        // Starvation escape: 4 D grants over a pending I, then I is forced
        bus.d_address = 32'h0000_5000; bus.d_read = 1'b1;
        bus.i_address = 32'h0000_6000; bus.i_read = 1'b1;
        for (int g = 0; g < 4; g++) begin
            tick();
            chka($sformatf("t3_d_grant%0d_addr", g), bus.mem_address, 32'h0000_5000);
            serve(1, R4);
            chk_resp($sformatf("t3_d_grant%0d", g), 1'b1, 1'b0, 1'b0);
            bus.d_read = 1'b0;
            tick();
            bus.d_read = 1'b1;
        end
        chka("t3_starve_full", 32'(dut.starve_cnt), 32'd4);
        tick();
        chka("t3_i_forced_addr", bus.mem_address, 32'h0000_6000);
        chk1("t3_i_mem_read", bus.mem_read, 1'b1);
        chka("t3_starve_clear", 32'(dut.starve_cnt), 32'd0);
        serve(1, R2);
        chk_resp("t3_i_resp", 1'b0, 1'b1, 1'b0);
        bus.i_read = 1'b0;
        tick();
        tick();
        chka("t3_d_after_i", bus.mem_address, 32'h0000_5000);
        serve(1, R1);
        chk_resp("t3_d_final", 1'b1, 1'b0, 1'b0);
        bus.d_read = 1'b0;
        tick();

        // D read and write together: write wins
        bus.d_address = 32'h0000_7000; bus.d_read = 1'b1; bus.d_write = 1'b1; bus.d_wdata = W2;
        tick();
        chk1("t4_mem_write", bus.mem_write, 1'b1);
        chk1("t4_mem_read", bus.mem_read, 1'b0);
        chkl("t4_mem_wdata", bus.mem_wdata, W2);
        serve(1, '0);
        bus.d_read = 1'b0; bus.d_write = 1'b0;
        tick();

        // Spurious mem_resp in IDLE is ignored
        bus.mem_resp = 1'b1;
        tick();
        bus.mem_resp = 1'b0;
        chk_resp("t5_spurious", 1'b0, 1'b0, 1'b0);
        chk1("t5_spurious_read", bus.mem_read, 1'b0);
        tick();
        chk_resp("t5_spurious_next", 1'b0, 1'b0, 1'b0);

        // PF arriving during a D transaction waits for D's RESP and IDLE
        bus.d_address = 32'h0000_8000; bus.d_read = 1'b1;
        tick();
        bus.pf_address = 32'h0000_9000; bus.pf_read = 1'b1;
        serve(3, R3);
        chk_resp("t5_d_resp", 1'b1, 1'b0, 1'b0);
        bus.d_read = 1'b0;
        tick();
        chk1("t5_idle_read", bus.mem_read, 1'b0);
        tick();
        chka("t5_pf_address", bus.mem_address, 32'h0000_9000);
        chk1("t5_pf_read", bus.mem_read, 1'b1);
        serve(1, R4);
        chk_resp("t5_pf_resp", 1'b0, 1'b0, 1'b1);
        bus.pf_read = 1'b0;
        tick();

        // Reset in the middle of a D read drops the transaction
        bus.d_address = 32'h0000_A000; bus.d_read = 1'b1;
        tick();
        chk1("t6_busy_read", bus.mem_read, 1'b1);
        rst = 1'b1;
        bus.d_read = 1'b0;
        #1;
        chk1("t6_rst_mem_read", bus.mem_read, 1'b0);
        chka("t6_rst_address", bus.mem_address, 32'h0);
        chkl("t6_rst_rdata", bus.d_rdata, '0);
        tick();
        chk_resp("t6_rst_resp", 1'b0, 1'b0, 1'b0);
        rst = 1'b0;
        tick();
        chk_resp("t6_after_rst", 1'b0, 1'b0, 1'b0);
        chk1("t6_after_rst_read", bus.mem_read, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
